// File: rtl/pll_rst_seq.sv
// PLL supervisor and staggered reset sequencer. It holds the PLL in reset, qualifies LOCK,
// releases NUM_CH reset domains in order, and aborts on lock loss or a forced re-lock.
module pll_rst_seq #(
    parameter int unsigned NUM_CH        = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned STAGE_GAP     = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_lock_in,
    input  logic              i_force_relock,
    output logic              o_pll_reset,
    output logic [NUM_CH-1:0] o_ch_resetn,
    output logic              o_all_ready,
    output logic [2:0]        o_state,
    output logic [7:0]        o_retry_cnt,
    output logic [7:0]        o_lock_loss_cnt
);
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [NUM_CH-1:0]      r_ch_resetn;
    logic [NUM_CH-1:0]      w_ch_resetn_nxt;
    logic [7:0]             r_retry_cnt;
    logic [7:0]             w_retry_cnt_nxt;
    logic [7:0]             r_lock_loss_cnt;
    logic [7:0]             w_lock_loss_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic                   w_abort;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state         <= StPllRst;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_ch_resetn     <= '0;
            r_retry_cnt     <= '0;
            r_lock_loss_cnt <= '0;
            r_sync          <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_idx           <= w_idx_nxt;
            r_ch_resetn     <= w_ch_resetn_nxt;
            r_retry_cnt     <= w_retry_cnt_nxt;
            r_lock_loss_cnt <= w_lock_loss_cnt_nxt;
            r_sync          <= {r_sync[SYNC_STAGES-2:0], i_lock_in};
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_idx_nxt           = r_idx;
        w_ch_resetn_nxt     = r_ch_resetn;
        w_retry_cnt_nxt     = r_retry_cnt;
        w_lock_loss_cnt_nxt = r_lock_loss_cnt;
        w_abort             = 1'b0;

        // A forced re-lock outranks lock loss and is not counted as one.
        if (i_force_relock && (r_state != StPllRst)) begin
            w_abort = 1'b1;
        end else if (!w_lock_s && ((r_state == StRelease) || (r_state == StRun))) begin
            w_abort = 1'b1;
            if (r_lock_loss_cnt != 8'hFF) begin
                w_lock_loss_cnt_nxt = r_lock_loss_cnt + 8'd1;
            end
        end

        if (w_abort) begin
            w_state_nxt     = StPllRst;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            w_ch_resetn_nxt = '0;
        end else begin
            case (r_state)
                StPllRst: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = StWaitLock;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                StWaitLock: begin
                    if (w_lock_s) begin
                        w_state_nxt = StStable;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_state_nxt = StPllRst;
                        w_cnt_nxt   = '0;
                        if (r_retry_cnt != 8'hFF) begin
                            w_retry_cnt_nxt = r_retry_cnt + 8'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                StStable: begin
                    if (!w_lock_s) begin
                        w_state_nxt = StWaitLock;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_nxt        = StRelease;
                        w_cnt_nxt          = '0;
                        w_idx_nxt          = '0;
                        w_ch_resetn_nxt[0] = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                StRelease: begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = StRun;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                            for (int k = 1; k < NUM_CH; k++) begin
                                if (IDX_W'(k - 1) == r_idx) begin
                                    w_ch_resetn_nxt[k] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                StRun: begin
                    w_state_nxt = StRun;
                end
                default: begin
                    w_state_nxt = StPllRst;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign o_pll_reset     = (r_state == StPllRst);
    assign o_all_ready     = (r_state == StRun);
    assign o_state         = r_state;
    assign o_ch_resetn     = r_ch_resetn;
    assign o_retry_cnt     = r_retry_cnt;
    assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus a random soak, checked cycle by cycle
// against a timestamp-based model of the sequencing rules.
module tb_pll_rst_seq;
    localparam int NUM_CH        = 3;
    localparam int SYNC_STAGES   = 2;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int STAGE_GAP     = 3;
    localparam int CNT_W         = 16;
    localparam int VW            = 21 + NUM_CH;

    localparam logic [VW-1:0] RST_VEC = {3'd0, 1'b1, {NUM_CH{1'b0}}, 1'b0, 8'd0, 8'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              lock_in;
    logic              force_relock;
    logic              pll_reset;
    logic [NUM_CH-1:0] ch_resetn;
    logic              all_ready;
    logic [2:0]        state;
    logic [7:0]        retry_cnt;
    logic [7:0]        lock_loss_cnt;

    pll_rst_seq #(
        .NUM_CH       (NUM_CH),
        .SYNC_STAGES  (SYNC_STAGES),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .STAGE_GAP    (STAGE_GAP),
        .CNT_W        (CNT_W)
    ) u_dut (
        .i_clk          (clk),
        .i_resetn       (resetn),
        .i_lock_in      (lock_in),
        .i_force_relock (force_relock),
        .o_pll_reset    (pll_reset),
        .o_ch_resetn    (ch_resetn),
        .o_all_ready    (all_ready),
        .o_state        (state),
        .o_retry_cnt    (retry_cnt),
        .o_lock_loss_cnt(lock_loss_cnt)
    );

    logic [VW-1:0] w_obs;
    assign w_obs = {state, pll_reset, ch_resetn, all_ready, retry_cnt, lock_loss_cnt};

    int checks = 0;
    int errors = 0;

    // Model: phase number, edge at which it was entered, released-channel count, counters.
    int                     m_cyc   = 0;
    int                     m_entry = 0;
    int                     m_ph    = 0;
    int                     m_nrel  = 0;
    int                     m_retry = 0;
    int                     m_loss  = 0;
    logic [SYNC_STAGES-1:0] m_hist  = '0;

    task automatic enter(input int ph);
        m_ph    = ph;
        m_entry = m_cyc;
    endtask

    task automatic model_abort();
        enter(0);
        m_nrel = 0;
    endtask

    task automatic model_step(input logic rstn, input logic lk, input logic frc);
        logic ls;
        int   e;
        m_cyc++;
        ls     = m_hist[SYNC_STAGES-1];
        m_hist = {m_hist[SYNC_STAGES-2:0], lk};
        e      = m_cyc - m_entry;
        if (!rstn) begin
            m_hist  = '0;
            enter(0);
            m_nrel  = 0;
            m_retry = 0;
            m_loss  = 0;
        end else if (frc && m_ph != 0) begin
            model_abort();
        end else if (!ls && m_ph >= 3) begin
            model_abort();
            if (m_loss < 255) m_loss++;
        end else begin
            case (m_ph)
                0: if (e == RST_CYCLES) enter(1);
                1: begin
                    if (ls) enter(2);
                    else if (e == LOCK_TIMEOUT) begin
                        enter(0);
                        if (m_retry < 255) m_retry++;
                    end
                end
                2: begin
                    if (!ls) enter(1);
                    else if (e == STABLE_CYCLES) begin
                        enter(3);
                        m_nrel = 1;
                    end
                end
                3: begin
                    if (e % STAGE_GAP == 0) begin
                        if (e / STAGE_GAP >= NUM_CH) enter(4);
                        else m_nrel = e / STAGE_GAP + 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_CH-1:0] ch;
        ch = NUM_CH'((1 << m_nrel) - 1);
        return {3'(m_ph), (m_ph == 0), ch, (m_ph == 4), 8'(m_retry), 8'(m_loss)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(resetn, lock_in, force_relock);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        lock_in      = 1'b0;
        force_relock = 1'b0;
        tick();
        tick();
        checks++;
        if (w_obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", w_obs, RST_VEC);
        end
        checks++;
        if (w_obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", w_obs, exp_vec());
        end
    endtask

    task automatic test_nominal();
        int n;
        resetn = 1'b1;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            n++;
            tick();
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL nominal_rst t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL nominal_pll_reset_width: got %0d want %0d", n, RST_CYCLES);
        end
        for (int i = 0; i < 4; i++) tick();
        lock_in = 1'b1;
        n = 0;
        while (ch_resetn[0] !== 1'b1 && n < 100) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL nominal_lock t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        checks++;
        if (n != SYNC_STAGES + 1 + STABLE_CYCLES) begin
            errors++;
            $display("FAIL nominal_lock_to_ch0: got %0d edges want %0d", n,
                     SYNC_STAGES + 1 + STABLE_CYCLES);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL nominal_release t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (ch_resetn !== 3'b011) begin
                    errors++;
                    $display("FAIL nominal_ch_plus3: got %b want 011", ch_resetn);
                end
            end else if (i == 6) begin
                checks++;
                if (ch_resetn !== 3'b111) begin
                    errors++;
                    $display("FAIL nominal_ch_plus6: got %b want 111", ch_resetn);
                end
            end else if (i == 9) begin
                checks++;
                if (all_ready !== 1'b1 || state !== 3'd4) begin
                    errors++;
                    $display("FAIL nominal_run_plus9: got ready=%b state=%0d want 1/4",
                             all_ready, state);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int   last_rise;
        logic prev;
        resetn  = 1'b0;
        lock_in = 1'b0;
        tick();
        resetn    = 1'b1;
        last_rise = -1;
        prev      = pll_reset;
        for (int i = 0; i < 255 * 24 + 60; i++) begin
            tick();
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL timeout t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
            if (pll_reset === 1'b1 && prev === 1'b0) begin
                if (last_rise >= 0) begin
                    checks++;
                    if (m_cyc - last_rise != RST_CYCLES + LOCK_TIMEOUT) begin
                        errors++;
                        $display("FAIL timeout_period: got %0d want %0d", m_cyc - last_rise,
                                 RST_CYCLES + LOCK_TIMEOUT);
                    end
                end
                last_rise = m_cyc;
            end
            prev = pll_reset;
        end
        checks++;
        if (retry_cnt !== 8'd255 || ch_resetn !== 3'b000) begin
            errors++;
            $display("FAIL timeout_saturate: got retry=%0d ch=%b want 255/000", retry_cnt,
                     ch_resetn);
        end
    endtask

    task automatic test_glitch();
        int   n;
        int   off;
        logic seen1;
        logic seen2;
        resetn = 1'b0;
        tick();
        resetn  = 1'b1;
        lock_in = 1'b1;
        n = 0;
        while (state !== 3'd2 && n < 100) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL glitch_pre t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        off = $urandom_range(0, 4);
        for (int i = 0; i < off; i++) tick();
        lock_in = 1'b0;
        tick();
        lock_in = 1'b1;
        seen1   = 1'b0;
        seen2   = 1'b0;
        n = 0;
        while (all_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL glitch t=%0d off=%0d: got %h want %h", m_cyc, off, w_obs,
                         exp_vec());
            end
            if (state === 3'd1) seen1 = 1'b1;
            else if (seen1 && state === 3'd2) seen2 = 1'b1;
        end
        checks++;
        if (!(seen1 && seen2) || all_ready !== 1'b1) begin
            errors++;
            $display("FAIL glitch_path: got seen1=%b seen2=%b ready=%b want 1/1/1", seen1, seen2,
                     all_ready);
        end
        checks++;
        if (retry_cnt !== 8'd0 || lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL glitch_counters: got %0d/%0d want 0/0", retry_cnt, lock_loss_cnt);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        lock_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL loss t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
            if (i == 2) begin
                checks++;
                if (all_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL loss_early: got ready=%b want 1", all_ready);
                end
            end
        end
        checks++;
        if (ch_resetn !== 3'b000 || all_ready !== 1'b0 || pll_reset !== 1'b1 ||
            lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL loss_response: got ch=%b rdy=%b pll=%b loss=%0d want 000/0/1/1",
                     ch_resetn, all_ready, pll_reset, lock_loss_cnt);
        end
        lock_in = 1'b1;
        n = 0;
        while (all_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL loss_relock t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        checks++;
        if (all_ready !== 1'b1) begin
            errors++;
            $display("FAIL loss_rerun: got ready=%b want 1", all_ready);
        end
    endtask

    task automatic test_force();
        int         n;
        logic [7:0] loss0;
        resetn = 1'b0;
        tick();
        resetn  = 1'b1;
        lock_in = 1'b1;
        n = 0;
        while (ch_resetn !== 3'b001 && n < 200) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL force_pre t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        loss0        = lock_loss_cnt;
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        checks++;
        if (ch_resetn !== 3'b000 || state !== 3'd0 || lock_loss_cnt !== loss0) begin
            errors++;
            $display("FAIL force_abort: got ch=%b state=%0d loss=%0d want 000/0/%0d", ch_resetn,
                     state, lock_loss_cnt, loss0);
        end
        n = 1;
        while (pll_reset === 1'b1 && n < 50) begin
            force_relock = (n == 1);
            tick();
            force_relock = 1'b0;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL force_rst t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
            if (pll_reset === 1'b1) n++;
        end
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL force_in_pll_rst_width: got %0d want %0d", n, RST_CYCLES);
        end
    endtask

    task automatic test_resetn_mid();
        int n;
        resetn = 1'b0;
        tick();
        resetn  = 1'b1;
        lock_in = 1'b0;
        n = 0;
        while (retry_cnt !== 8'd2 && n < 200) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_retry t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        lock_in = 1'b1;
        n = 0;
        while (ch_resetn !== 3'b011 && n < 200) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_rel t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        checks++;
        if (retry_cnt !== 8'd2 || ch_resetn !== 3'b011) begin
            errors++;
            $display("FAIL rstmid_setup: got retry=%0d ch=%b want 2/011", retry_cnt, ch_resetn);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (w_obs !== RST_VEC) begin
            errors++;
            $display("FAIL rstmid_values: got %h want %h", w_obs, RST_VEC);
        end
        n = 0;
        while (all_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_restart t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                lock_in = ~lock_in;
                hold    = lock_in ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 30));
            end else begin
                hold--;
            end
            force_relock = ($urandom_range(0, 149) == 0);
            resetn       = ($urandom_range(0, 599) != 0);
            tick();
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL random t=%0d: got %h want %h", m_cyc, w_obs, exp_vec());
            end
        end
        force_relock = 1'b0;
        resetn       = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_force();
        test_resetn_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
